// File: rtl/button_conditioner_if.sv
// Button bundle between the raw push-button pins and the game core.
// The master side drives the raw buttons; the slave side (the conditioner)
// returns one-cycle qualified press pulses.
interface button_conditioner_if;

    logic Start;
    logic Stop;
    logic BestScore;
    logic StartP;
    logic StopP;
    logic BestP;

    modport master (
        output Start,
        output Stop,
        output BestScore,
        input  StartP,
        input  StopP,
        input  BestP
    );

    modport slave (
        input  Start,
        input  Stop,
        input  BestScore,
        output StartP,
        output StopP,
        output BestP
    );

endinterface

// File: rtl/button_conditioner.sv
// Three identical, independent push-button conditioners. Each raw button is
// brought into the Clk domain with a two-flop synchronizer and then qualified
// by a four-state debounce FSM that emits a single registered pulse per
// qualified press. Channel 0 is Start, channel 1 is Stop, channel 2 is BestScore.
module button_conditioner #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input  logic                 Clk,
    input  logic                 Reset,
    button_conditioner_if.slave  btn
);

    localparam int NUM_CH = 3;
    localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // REL_CHK is the reset state so that a button held through reset is
    // first recognised as HELD instead of being mistaken for a fresh press.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } chanState_t;

    logic [NUM_CH-1:0] rawIn;
    logic [NUM_CH-1:0] syncStage1;
    logic [NUM_CH-1:0] syncStage2;
    logic [NUM_CH-1:0] pulseOut;

    assign rawIn = {btn.BestScore, btn.Stop, btn.Start};

    // Two-flop synchronizer for all raw buttons; only the second stage is
    // ever looked at by the channel FSMs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            syncStage1 <= '0;
            syncStage2 <= '0;
        end else begin
            syncStage1 <= rawIn;
            syncStage2 <= syncStage1;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gChannel

        chanState_t        stateReg;
        chanState_t        stateNext;
        logic [CNT_W-1:0]  countReg;
        logic [CNT_W-1:0]  countNext;
        logic              pulseReg;
        logic              pulseNext;
        logic              level;

        assign level        = syncStage2[ch];
        assign pulseOut[ch] = pulseReg;

        // State, qualification counter and pulse register; reset parks the
        // channel in REL_CHK with a cleared count and no pulse, which also
        // suppresses any pulse that would have been issued on this edge.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                stateReg <= REL_CHK;
                countReg <= CNT_ZERO;
                pulseReg <= 1'b0;
            end else begin
                stateReg <= stateNext;
                countReg <= countNext;
                pulseReg <= pulseNext;
            end
        end

        // Debounce decision: a level must persist for DB_CYCLES checks before
        // a press is accepted or a release re-arms the channel; the counter
        // stops at DB_MAX because reaching it always leaves the check state.
        always_comb begin
            stateNext = stateReg;
            countNext = countReg;
            pulseNext = 1'b0;
            case (stateReg)
                IDLE: begin
                    if (level) begin
                        stateNext = PRESS_CHK;
                        countNext = CNT_ONE;
                    end
                end
                PRESS_CHK: begin
                    if (!level) begin
                        stateNext = IDLE;
                        countNext = CNT_ZERO;
                    end else if (countReg < DB_MAX) begin
                        countNext = countReg + 1'b1;
                    end else begin
                        stateNext = HELD;
                        countNext = CNT_ZERO;
                        pulseNext = 1'b1;
                    end
                end
                HELD: begin
                    if (!level) begin
                        stateNext = REL_CHK;
                        countNext = CNT_ONE;
                    end
                end
                REL_CHK: begin
                    if (level) begin
                        stateNext = HELD;
                        countNext = CNT_ZERO;
                    end else if (countReg < DB_MAX) begin
                        countNext = countReg + 1'b1;
                    end else begin
                        stateNext = IDLE;
                        countNext = CNT_ZERO;
                    end
                end
                default: begin
                    stateNext = REL_CHK;
                    countNext = CNT_ZERO;
                end
            endcase
        end

    end : gChannel

    assign btn.StartP = pulseOut[0];
    assign btn.StopP  = pulseOut[1];
    assign btn.BestP  = pulseOut[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4. Every press that
// should qualify pushes the channel and the cycle its pulse is due into a
// scoreboard queue; a negedge monitor pops and compares whenever a pulse
// appears, and leftover entries at the end count as missing pulses.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int LATENCY = DB + 3;

    typedef struct {
        int ch;
        int cyc;
    } expPulse_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    expPulse_t expQ[$];

    button_conditioner_if ifc ();

    button_conditioner #(
        .DB_CYCLES (DB),
        .CNT_W     (4)
    ) dut (
        .Clk   (clock),
        .Reset (reset),
        .btn   (ifc)
    );

    // Free-running clock and edge counter used to timestamp pulses.
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    // Drives reset and the three raw buttons at a falling edge, then lets
    // the requested number of cycles go by.
    task automatic applyStimulus(input logic rst, input logic st, input logic sp,
                                 input logic bs, input int nCycles);
        reset         = rst;
        ifc.Start     = st;
        ifc.Stop      = sp;
        ifc.BestScore = bs;
        repeat (nCycles) @(negedge clock);
    endtask

    // A raw edge driven now is sampled at edge cyc+1; its pulse follows
    // edge cyc+1+DB+2.
    task automatic expectPulse(input int ch);
        expPulse_t e;
        e.ch  = ch;
        e.cyc = cyc + LATENCY;
        expQ.push_back(e);
    endtask

    task automatic scorePulse(input int ch);
        expPulse_t e;
        checkOutput("pulseExpected", int'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("pulseChannel", ch, e.ch);
            checkOutput("pulseCycle", cyc, e.cyc);
        end
    endtask

    // Monitor: every observed pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (ifc.StartP === 1'b1) scorePulse(0);
        if (ifc.StopP  === 1'b1) scorePulse(1);
        if (ifc.BestP  === 1'b1) scorePulse(2);
    end

    initial begin
        ifc.Start     = 1'b0;
        ifc.Stop      = 1'b0;
        ifc.BestScore = 1'b0;
        @(negedge clock);

        // Reset for two cycles, outputs cleared.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("rstStartP", int'(ifc.StartP), 0);
        checkOutput("rstStopP",  int'(ifc.StopP),  0);
        checkOutput("rstBestP",  int'(ifc.BestP),  0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("rstStartP2", int'(ifc.StartP), 0);
        checkOutput("rstStopP2",  int'(ifc.StopP),  0);
        checkOutput("rstBestP2",  int'(ifc.BestP),  0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10);

        // Clean Start press held for 20 cycles.
        $display("[TB] clean start press");
        expectPulse(0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12);

        // Bouncing Start: two short highs, then a stable press.
        $display("[TB] bouncing start press");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2);
        expectPulse(0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12);

        // Start and Stop together: pulses land in the same cycle.
        $display("[TB] simultaneous start and stop");
        expectPulse(0);
        expectPulse(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12);

        // Stop with a two-cycle release glitch: one pulse only.
        $display("[TB] stop release glitch");
        expectPulse(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12);

        // BestScore held through reset: no pulse until released and re-pressed.
        $display("[TB] bestscore held through reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10);
        expectPulse(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12);

        // Reset three cycles into a Start press discards it.
        $display("[TB] reset mid press-check");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10);
        expectPulse(0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12);

        // Reset on the very edge a Stop pulse would be issued suppresses it.
        $display("[TB] reset collides with pulse");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
        checkOutput("rstCollideStopP", int'(ifc.StopP), 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12);

        checkOutput("pendingPulses", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
